// File: rtl/logicnet_lut_pkg.sv
// Shared definitions for the runtime-loadable LogicNets LUT layer slot.
// Holds default geometry, the controller state encoding and sizing helpers.
package logicnet_lut_pkg;

  localparam int IN_BITS_DEF   = 6;
  localparam int OUT_BITS_DEF  = 1;
  localparam int LUT_DEPTH_DEF = 2 ** IN_BITS_DEF;

  typedef enum logic [1:0] {
    UNPROG = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2
  } lut_state_e;

  function automatic int lut_depth(input int in_bits);
    return 1 << in_bits;
  endfunction

  // Number of configuration beats needed to fill every neuron's truth table.
  function automatic int beat_count(input int n_neurons, input int in_bits);
    return n_neurons * lut_depth(in_bits);
  endfunction

endpackage

// File: rtl/lut_ram_neuron.sv
// One writable truth-table neuron: distributed RAM with synchronous write,
// asynchronous read and a registered, enable-gated output.
module lut_ram_neuron
  import logicnet_lut_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic                re,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int LUT_DEPTH = lut_depth(IN_BITS);

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [OUT_BITS-1:0] mem [LUT_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; table contents stay undefined until loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/logicnet_lut_programmer.sv
// Layer slot of N_NEURONS reprogrammable LUT neurons: a config stream fills
// the tables in order, then one packed input vector is evaluated per cycle.
module logicnet_lut_programmer
  import logicnet_lut_pkg::*;
#(
  parameter int IN_BITS   = IN_BITS_DEF,
  parameter int OUT_BITS  = OUT_BITS_DEF,
  parameter int N_NEURONS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [OUT_BITS-1:0]           cfg_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  output logic                          loaded,
  output logic                          cfg_err
);

  localparam int NIDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  localparam logic [1:0] ST_UNPROG = 2'(UNPROG);
  localparam logic [1:0] ST_LOAD   = 2'(LOAD);
  localparam logic [1:0] ST_RUN    = 2'(RUN);

  localparam logic [IN_BITS-1:0] ADDR_MAX    = '1;
  localparam logic [NIDX_W-1:0]  LAST_NEURON = NIDX_W'(N_NEURONS - 1);

  logic [1:0]         state;
  logic [NIDX_W-1:0]  neuron_idx;
  logic [IN_BITS-1:0] addr;
  logic               beat_acc;
  logic               rd_en;
  logic               last_beat;

  assign cfg_ready = (state == ST_LOAD);
  assign in_ready  = (state == ST_RUN);

  // A restart pulse wins over any beat or vector presented in the same cycle.
  assign beat_acc  = cfg_valid && cfg_ready && !cfg_start;
  assign rd_en     = in_valid && in_ready && !cfg_start;
  assign last_beat = (neuron_idx == LAST_NEURON) && (addr == ADDR_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_UNPROG;
      neuron_idx <= '0;
      addr       <= '0;
      loaded     <= 1'b0;
    end else if (cfg_start) begin
      state      <= ST_LOAD;
      neuron_idx <= '0;
      addr       <= '0;
      loaded     <= 1'b0;
    end else if (beat_acc) begin
      addr <= addr + 1'b1;
      if (addr == ADDR_MAX) begin
        if (last_beat) begin
          state      <= ST_RUN;
          loaded     <= 1'b1;
          neuron_idx <= '0;
        end else begin
          neuron_idx <= neuron_idx + 1'b1;
        end
      end
    end
  end

  // Any beat outside LOAD is a protocol error that latches until the next restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_en;
      if (cfg_start) begin
        cfg_err <= 1'b0;
      end else if (cfg_valid && (state != ST_LOAD)) begin
        cfg_err <= 1'b1;
      end
    end
  end

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    localparam logic [NIDX_W-1:0] MY_IDX = NIDX_W'(n);

    logic we_n;
    assign we_n = beat_acc && (neuron_idx == MY_IDX);

    lut_ram_neuron #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_lut (
      .clk   (clk),
      .rst   (rst),
      .we    (we_n),
      .waddr (addr),
      .wdata (cfg_data),
      .re    (rd_en),
      .raddr (in_data[n*IN_BITS +: IN_BITS]),
      .rdata (out_data[n*OUT_BITS +: OUT_BITS])
    );
  end

endmodule

// File: tb/tb_logicnet_lut_programmer.sv
// Self-checking bench for logicnet_lut_programmer with a two-neuron, 6-bit slot;
// expected results come from a plain array model of the loaded truth tables.
module tb_logicnet_lut_programmer;
  import logicnet_lut_pkg::*;

  localparam int IB    = 6;
  localparam int OB    = 1;
  localparam int NN    = 2;
  localparam int DEPTH = 64;
  localparam int TOTAL = NN * DEPTH;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [OB-1:0]       cfg_data;
  logic                in_valid;
  logic                in_ready;
  logic [NN*IB-1:0]    in_data;
  logic                out_valid;
  logic [NN*OB-1:0]    out_data;
  logic                loaded;
  logic                cfg_err;

  int checks = 0;
  int fails  = 0;

  bit [OB-1:0] model_lut [NN][DEPTH];
  bit [OB-1:0] pend      [NN][DEPTH];

  logicnet_lut_programmer #(
    .IN_BITS   (IB),
    .OUT_BITS  (OB),
    .N_NEURONS (NN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .loaded    (loaded),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [OB-1:0] d,
                               input logic iv, input logic [NN*IB-1:0] id);
    cfg_start = s;
    cfg_valid = v;
    cfg_data  = d;
    in_valid  = iv;
    in_data   = id;
  endtask

  function automatic logic [NN*OB-1:0] exp_out(input logic [NN*IB-1:0] id);
    logic [NN*OB-1:0] r;
    r = '0;
    for (int n = 0; n < NN; n++) r[n*OB +: OB] = model_lut[n][id[n*IB +: IB]];
    return r;
  endfunction

  function automatic logic [NN*IB-1:0] same_addr(input int a);
    logic [NN*IB-1:0] r;
    for (int n = 0; n < NN; n++) r[n*IB +: IB] = IB'(a);
    return r;
  endfunction

  task automatic stream_beats(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      applyStimulus(1'b0, 1'b1, pend[k / DEPTH][k % DEPTH], 1'b0, '0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic commit_model();
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++) model_lut[n][a] = pend[n][a];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, '1);
    tick();
    tick();
    checks += 6;
    if (cfg_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_cfg_ready: got %b expected 0", cfg_ready); end
    if (in_ready  !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data  !== '0)   begin fails++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    if (loaded    !== 1'b0) begin fails++; $display("[TB] FAIL reset_loaded: got %b expected 0", loaded); end
    if (cfg_err   !== 1'b0) begin fails++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    rst = 1'b0;
    tick();
    checks += 2;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL unprog_out_valid: got %b expected 0", out_valid); end
    if (in_ready  !== 1'b0) begin fails++; $display("[TB] FAIL unprog_in_ready: got %b expected 0", in_ready); end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    checks += 2;
    if (cfg_err   !== 1'b1) begin fails++; $display("[TB] FAIL unprog_cfg_err: got %b expected 1", cfg_err); end
    if (cfg_ready !== 1'b0) begin fails++; $display("[TB] FAIL unprog_cfg_ready: got %b expected 0", cfg_ready); end
  endtask

  task automatic test_parity_load();
    logic [IB-1:0] a6;
    for (int a = 0; a < DEPTH; a++) begin
      a6 = IB'(a);
      pend[0][a] = a6[5];
      pend[1][a] = ^a6;
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    checks += 3;
    if (cfg_ready !== 1'b1) begin fails++; $display("[TB] FAIL start_cfg_ready: got %b expected 1", cfg_ready); end
    if (cfg_err   !== 1'b0) begin fails++; $display("[TB] FAIL start_clears_err: got %b expected 0", cfg_err); end
    if (loaded    !== 1'b0) begin fails++; $display("[TB] FAIL start_loaded: got %b expected 0", loaded); end
    stream_beats(0, TOTAL);
    commit_model();
    checks += 3;
    if (loaded    !== 1'b1) begin fails++; $display("[TB] FAIL parity_loaded: got %b expected 1", loaded); end
    if (cfg_ready !== 1'b0) begin fails++; $display("[TB] FAIL parity_cfg_ready: got %b expected 0", cfg_ready); end
    if (in_ready  !== 1'b1) begin fails++; $display("[TB] FAIL parity_in_ready: got %b expected 1", in_ready); end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, {6'b000111, 6'b100000});
    tick();
    checks += 2;
    if (out_valid !== 1'b1)  begin fails++; $display("[TB] FAIL parity_vec1_valid: got %b expected 1", out_valid); end
    if (out_data  !== 2'b11) begin fails++; $display("[TB] FAIL parity_vec1_data: got %b expected 11", out_data); end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    checks += 2;
    if (out_valid !== 1'b0)  begin fails++; $display("[TB] FAIL parity_idle_valid: got %b expected 0", out_valid); end
    if (out_data  !== 2'b11) begin fails++; $display("[TB] FAIL parity_hold_data: got %b expected 11", out_data); end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, {6'b000011, 6'b011111});
    tick();
    checks += 2;
    if (out_valid !== 1'b1)  begin fails++; $display("[TB] FAIL parity_vec2_valid: got %b expected 1", out_valid); end
    if (out_data  !== 2'b00) begin fails++; $display("[TB] FAIL parity_vec2_data: got %b expected 00", out_data); end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_stalled_load();
    int beat;
    int cyc;
    logic [NN*IB-1:0] id;
    logic [NN*OB-1:0] exp;
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++) pend[n][a] = OB'($urandom);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    beat = 0;
    cyc  = 0;
    while (beat < TOTAL) begin
      if (cyc % 3 == 2) begin
        applyStimulus(1'b0, 1'b0, OB'($urandom), 1'b1, '0);
      end else begin
        applyStimulus(1'b0, 1'b1, pend[beat / DEPTH][beat % DEPTH], 1'b1, '0);
        beat++;
      end
      tick();
      cyc++;
      if (beat < TOTAL) begin
        checks++;
        if (loaded !== 1'b0) begin fails++; $display("[TB] FAIL stall_early_loaded: beat %0d got %b expected 0", beat, loaded); end
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    commit_model();
    checks += 2;
    if (loaded    !== 1'b1) begin fails++; $display("[TB] FAIL stall_loaded: got %b expected 1", loaded); end
    if (cfg_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_cfg_ready: got %b expected 0", cfg_ready); end
    for (int i = 0; i < 32; i++) begin
      id  = (NN*IB)'($urandom);
      exp = exp_out(id);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, id);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        fails++;
        $display("[TB] FAIL stall_read: in %h got valid %b data %h expected 1 %h", id, out_valid, out_data, exp);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_restart();
    logic [NN*OB-1:0] exp;
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++) pend[n][a] = OB'($urandom);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    stream_beats(0, 70);
    applyStimulus(1'b1, 1'b1, OB'($urandom), 1'b1, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, '0);
    checks += 4;
    if (loaded    !== 1'b0) begin fails++; $display("[TB] FAIL restart_loaded: got %b expected 0", loaded); end
    if (in_ready  !== 1'b0) begin fails++; $display("[TB] FAIL restart_in_ready: got %b expected 0", in_ready); end
    if (cfg_ready !== 1'b1) begin fails++; $display("[TB] FAIL restart_cfg_ready: got %b expected 1", cfg_ready); end
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL restart_out_valid: got %b expected 0", out_valid); end
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++) pend[n][a] = ~model_lut[n][a];
    stream_beats(0, TOTAL);
    commit_model();
    checks++;
    if (loaded !== 1'b1) begin fails++; $display("[TB] FAIL reload_loaded: got %b expected 1", loaded); end
    for (int a = 0; a < DEPTH; a++) begin
      exp = exp_out(same_addr(a));
      applyStimulus(1'b0, 1'b0, '0, 1'b1, same_addr(a));
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        fails++;
        $display("[TB] FAIL reload_sweep: addr %0d got valid %b data %h expected 1 %h", a, out_valid, out_data, exp);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_streaming();
    logic [NN*IB-1:0] id;
    logic [NN*IB-1:0] id_b;
    logic [NN*OB-1:0] exp;
    logic [NN*OB-1:0] exp_b;
    for (int i = 0; i < DEPTH; i++) begin
      id = {IB'($urandom), IB'(i)};
      exp = exp_out(id);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, id);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        fails++;
        $display("[TB] FAIL stream_b2b: beat %0d got valid %b data %h expected 1 %h", i, out_valid, out_data, exp);
      end
    end
    id    = (NN*IB)'($urandom);
    id_b  = (NN*IB)'($urandom);
    exp   = exp_out(id);
    exp_b = exp_out(id_b);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, id);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, id_b);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== exp) begin
      fails++;
      $display("[TB] FAIL stream_gap: got valid %b data %h expected 0 %h", out_valid, out_data, exp);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, id_b);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_b) begin
      fails++;
      $display("[TB] FAIL stream_after_gap: got valid %b data %h expected 1 %h", out_valid, out_data, exp_b);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stream_tail_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_error();
    logic [NN*OB-1:0] exp;
    applyStimulus(1'b0, 1'b1, OB'($urandom), 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    checks += 2;
    if (cfg_err !== 1'b1) begin fails++; $display("[TB] FAIL err_set: got %b expected 1", cfg_err); end
    if (loaded  !== 1'b1) begin fails++; $display("[TB] FAIL err_loaded: got %b expected 1", loaded); end
    for (int a = 0; a < DEPTH; a++) begin
      exp = exp_out(same_addr(a));
      applyStimulus(1'b0, 1'b0, '0, 1'b1, same_addr(a));
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        fails++;
        $display("[TB] FAIL err_sweep: addr %0d got valid %b data %h expected 1 %h", a, out_valid, out_data, exp);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    checks++;
    if (cfg_err !== 1'b1) begin fails++; $display("[TB] FAIL err_sticky: got %b expected 1", cfg_err); end
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    checks += 3;
    if (cfg_err   !== 1'b0) begin fails++; $display("[TB] FAIL err_clear: got %b expected 0", cfg_err); end
    if (cfg_ready !== 1'b1) begin fails++; $display("[TB] FAIL err_restart_ready: got %b expected 1", cfg_ready); end
    if (loaded    !== 1'b0) begin fails++; $display("[TB] FAIL err_restart_loaded: got %b expected 0", loaded); end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    test_reset();
    test_parity_load();
    test_stalled_load();
    test_restart();
    test_streaming();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
